// File: rtl/ysyx_25040111_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// One single-beat transaction in flight at a time; the granted master's channels pass straight through.
module ysyx_25040111_arbiter #(
  parameter bit         RR_EN  = 1'b1,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  // IFU (M0)
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  input  logic        m0_rready,
  // LSU (M1)
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  input  logic        m1_rready,
  input  logic        m1_awvalid,
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awsize,
  output logic        m1_awready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  output logic        m1_wready,
  output logic        m1_bvalid,
  output logic [1:0]  m1_bresp,
  input  logic        m1_bready,
  // SoC master port
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid
);

  typedef enum logic [1:0] {IDLE, RD_M0, RD_M1, WR_M1} state_t;

  state_t state;
  logic   last_m1;
  logic   ar_done;
  logic   aw_done;
  logic   w_done;

  // IDs are single-valued and transactions never overlap, so rid/bid carry no information.
  logic unused_ids;
  assign unused_ids = ^{io_master_rid, io_master_bid};

  assign io_master_arid    = AXI_ID;
  assign io_master_awid    = AXI_ID;
  assign io_master_arlen   = 8'd0;
  assign io_master_awlen   = 8'd0;
  assign io_master_arburst = 2'b00;
  assign io_master_awburst = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m1_awvalid)
            state <= WR_M1;
          else if (m0_arvalid && m1_arvalid)
            state <= (RR_EN && last_m1) ? RD_M0 : RD_M1;
          else if (m0_arvalid)
            state <= RD_M0;
          else if (m1_arvalid)
            state <= RD_M1;
        end
        RD_M0, RD_M1: begin
          if (io_master_arvalid && io_master_arready)
            ar_done <= 1'b1;
          // A beat without rlast is not the end of a len=0 burst; keep waiting.
          if (io_master_rvalid && io_master_rready && io_master_rlast) begin
            state   <= IDLE;
            ar_done <= 1'b0;
            last_m1 <= (state == RD_M1);
          end
        end
        WR_M1: begin
          if (io_master_awvalid && io_master_awready)
            aw_done <= 1'b1;
          if (io_master_wvalid && io_master_wready)
            w_done <= 1'b1;
          if (io_master_bvalid && io_master_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            last_m1 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arsize  = '0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awsize  = '0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    m0_arready        = 1'b0;
    m0_rvalid         = 1'b0;
    m0_rdata          = '0;
    m0_rresp          = '0;
    m1_arready        = 1'b0;
    m1_rvalid         = 1'b0;
    m1_rdata          = '0;
    m1_rresp          = '0;
    m1_awready        = 1'b0;
    m1_wready         = 1'b0;
    m1_bvalid         = 1'b0;
    m1_bresp          = '0;
    case (state)
      RD_M0: begin
        io_master_arvalid = m0_arvalid & ~ar_done;
        io_master_araddr  = m0_araddr;
        io_master_arsize  = m0_arsize;
        m0_arready        = io_master_arready & ~ar_done;
        m0_rvalid         = io_master_rvalid;
        m0_rdata          = io_master_rdata;
        m0_rresp          = io_master_rresp;
        io_master_rready  = m0_rready;
      end
      RD_M1: begin
        io_master_arvalid = m1_arvalid & ~ar_done;
        io_master_araddr  = m1_araddr;
        io_master_arsize  = m1_arsize;
        m1_arready        = io_master_arready & ~ar_done;
        m1_rvalid         = io_master_rvalid;
        m1_rdata          = io_master_rdata;
        m1_rresp          = io_master_rresp;
        io_master_rready  = m1_rready;
      end
      WR_M1: begin
        // AW and W complete independently; either may finish first.
        io_master_awvalid = m1_awvalid & ~aw_done;
        io_master_awaddr  = m1_awaddr;
        io_master_awsize  = m1_awsize;
        m1_awready        = io_master_awready & ~aw_done;
        io_master_wvalid  = m1_wvalid & ~w_done;
        io_master_wdata   = m1_wdata;
        io_master_wstrb   = m1_wstrb;
        io_master_wlast   = m1_wlast;
        m1_wready         = io_master_wready & ~w_done;
        m1_bvalid         = io_master_bvalid;
        m1_bresp          = io_master_bresp;
        io_master_bready  = m1_bready;
      end
      default: ;
    endcase
  end

endmodule
